port_req_scheduler: RTL and testbench

- Shares one single-ported memory array among three requester ports (read or write) of the triple-ported memory.
- Each port owns a 1-deep pending register; a round-robin arbiter issues at most one access per cycle to the array.
- Read data is returned to the originating port with a one-hot valid.
- Sits between the port front-ends and the memory macro, upstream of the read serializers.

---
 rtl/port_req_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_port_req_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/port_req_scheduler.sv
// port_req_scheduler
//   Shares one single-ported memory array among three requester ports.
//   Each port owns a 1-deep pending register. An arbiter issues at most one
//   access per cycle to the array. Read data returns to the originating port
//   with a one-hot valid, three cycles after the request is presented.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   req_valid  per-port request valid (bit p = port p)
//   req_we     per-port write enable (1 = write, 0 = read)
//   req_addr   per-port address, port p at [p*ADDR_W +: ADDR_W]
//   req_wdata  per-port write data, port p at [p*WIDTH +: WIDTH]
//   freeze     per-port backpressure (registered); upstream holds while high
//   mem_stall  memory unavailable this cycle; nothing is issued
//   mem_en     array access strobe
//   mem_we     array write enable
//   mem_addr   array address
//   mem_wdata  array write data
//   mem_rdata  array read data, valid the cycle after a read issue
//   rd_valid   one-hot read-return valid (registered)
//   rd_data    read-return data (registered, holds between returns)
//
// Build option
//   PORT_REQ_SCHED_FIXED_PRIO_EN: when defined, strict priority
//   port 0 > port 1 > port 2 replaces round-robin and no pointer is kept.

module port_req_scheduler #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            req_valid,
  input  logic [2:0]            req_we,
  input  logic [3*ADDR_W-1:0]   req_addr,
  input  logic [3*WIDTH-1:0]    req_wdata,
  output logic [2:0]            freeze,
  input  logic                  mem_stall,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata,
  output logic [2:0]            rd_valid,
  output logic [WIDTH-1:0]      rd_data
);

  // Pending request registers, one per port.
  logic [2:0]        pending;
  logic [2:0]        pend_we;
  logic [ADDR_W-1:0] pend_addr  [3];
  logic [WIDTH-1:0]  pend_wdata [3];

  // Arbiter result.
  logic [2:0] grant;
  logic [1:0] grant_idx;
  logic       grant_any;

  // Read-return tag: which port the read issued last cycle belongs to.
  logic       tag_valid;
  logic [1:0] tag;

  // ---------------------------------------------------------------------
  // Capture / release of pending requests.
  // A granted port is always pending, so it can never also capture in the
  // same cycle; freeze therefore falls the cycle after the grant.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
      pend_we <= '0;
      for (int unsigned p = 0; p < 3; p++) begin
        pend_addr[p]  <= '0;
        pend_wdata[p] <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < 3; p++) begin
        if (req_valid[p] && !pending[p]) begin
          pending[p]    <= 1'b1;
          pend_we[p]    <= req_we[p];
          pend_addr[p]  <= req_addr[p*ADDR_W +: ADDR_W];
          pend_wdata[p] <= req_wdata[p*WIDTH +: WIDTH];
        end else if (grant[p]) begin
          pending[p] <= 1'b0;
        end
      end
    end
  end

  always_comb freeze = pending;

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
`ifdef PORT_REQ_SCHED_FIXED_PRIO_EN

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    if (!mem_stall) begin
      if (pending[0]) begin
        grant[0]  = 1'b1;
        grant_idx = 2'd0;
      end else if (pending[1]) begin
        grant[1]  = 1'b1;
        grant_idx = 2'd1;
      end else if (pending[2]) begin
        grant[2]  = 1'b1;
        grant_idx = 2'd2;
      end
    end
  end

`else

  // rr_ptr holds the last granted port; the search starts just after it.
  logic [1:0] rr_ptr;

  always_comb begin
    logic       found;
    logic [1:0] idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    if (!mem_stall) begin
      for (int unsigned k = 1; k <= 3; k++) begin
        idx = 2'((32'(rr_ptr) + k) % 3);
        if (!found && pending[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = idx;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= 2'd2;
    end else if (grant_any) begin
      rr_ptr <= grant_idx;
    end
  end

`endif

  always_comb grant_any = |grant;

  // ---------------------------------------------------------------------
  // Memory request drive; all fields are zero when nothing is issued.
  // ---------------------------------------------------------------------
  always_comb begin
    mem_en    = grant_any;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_any) begin
      mem_we    = pend_we[grant_idx];
      mem_addr  = pend_addr[grant_idx];
      mem_wdata = pend_wdata[grant_idx];
    end
  end

  // ---------------------------------------------------------------------
  // Read return path. Independent of mem_stall: a read already issued
  // always returns on schedule.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_valid <= 1'b0;
      tag       <= '0;
      rd_valid  <= '0;
      rd_data   <= '0;
    end else begin
      tag_valid <= grant_any && !pend_we[grant_idx];
      tag       <= grant_idx;
      if (tag_valid) begin
        rd_valid <= 3'b001 << tag;
        rd_data  <= mem_rdata;
      end else begin
        rd_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_port_req_scheduler.sv
module tb_port_req_scheduler;

  localparam int WIDTH  = 8;
  localparam int ADDR_W = 6;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic [2:0]          req_valid = '0;
  logic [2:0]          req_we = '0;
  logic [3*ADDR_W-1:0] req_addr = '0;
  logic [3*WIDTH-1:0]  req_wdata = '0;
  logic [2:0]          freeze;
  logic                mem_stall = 1'b0;
  logic                mem_en;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [WIDTH-1:0]    mem_wdata;
  logic [WIDTH-1:0]    mem_rdata = '0;
  logic [2:0]          rd_valid;
  logic [WIDTH-1:0]    rd_data;

  int total = 0;
  int bad   = 0;

  port_req_scheduler #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .freeze    (freeze),
    .mem_stall (mem_stall),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  // Memory macro stand-in: synchronous write, registered read.
  logic       preload = 1'b0;
  logic [7:0] tb_mem [64];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) tb_mem[i] <= 8'(i * 37 + 11);
    end else if (mem_en) begin
      if (mem_we) tb_mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= tb_mem[mem_addr];
    end
  end

  logic [29:0] dut_bus;
  assign dut_bus = {freeze, mem_en, mem_we, mem_addr, mem_wdata, rd_valid, rd_data};

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [64];
  logic [2:0] m_pend;
  logic [2:0] m_we;
  logic [5:0] m_addr  [3];
  logic [7:0] m_wdata [3];
  int         m_last;
  logic       m_ret_v;
  int         m_ret_p;
  logic [7:0] m_ret_d;
  logic [2:0] m_rv;
  logic [7:0] m_rd;
  int         m_g;
  logic [29:0] exp_bus;

  task model_reset();
    m_pend = '0; m_last = 2; m_ret_v = 1'b0; m_ret_p = 0; m_ret_d = '0;
    m_rv = '0; m_rd = '0; m_g = -1;
  endtask

  function int model_grant();
    int g;
    g = -1;
    if (!mem_stall) begin
`ifdef PORT_REQ_SCHED_FIXED_PRIO_EN
      for (int p = 2; p >= 0; p--) if (m_pend[p]) g = p;
`else
      for (int k = 3; k >= 1; k--) if (m_pend[(m_last + k) % 3]) g = (m_last + k) % 3;
`endif
    end
    return g;
  endfunction

  task set_in(input logic [2:0] v, input logic [2:0] w, input logic [17:0] a,
              input logic [23:0] d, input logic st);
    req_valid = v; req_we = w; req_addr = a; req_wdata = d; mem_stall = st;
  endtask

  // Settle after the inputs change, then form the expected outputs.
  task eval();
    #1;
    m_g = model_grant();
    if (m_g >= 0) exp_bus = {m_pend, 1'b1, m_we[m_g], m_addr[m_g], m_wdata[m_g], m_rv, m_rd};
    else          exp_bus = {m_pend, 1'b0, 1'b0, 6'h00, 8'h00, m_rv, m_rd};
  endtask

  // Apply the clock edge to the model, then move to the next falling edge.
  task advance();
    logic [2:0] old;
    old = m_pend;
    if (m_ret_v) begin m_rv = 3'b001 << m_ret_p; m_rd = m_ret_d; end
    else m_rv = '0;
    m_ret_v = 1'b0;
    if (m_g >= 0) begin
      if (m_we[m_g]) ref_mem[m_addr[m_g]] = m_wdata[m_g];
      else begin m_ret_v = 1'b1; m_ret_p = m_g; m_ret_d = ref_mem[m_addr[m_g]]; end
      m_pend[m_g] = 1'b0;
      m_last = m_g;
    end
    for (int p = 0; p < 3; p++) begin
      if (req_valid[p] && !old[p]) begin
        m_pend[p] = 1'b1; m_we[p] = req_we[p];
        m_addr[p] = req_addr[p*6 +: 6]; m_wdata[p] = req_wdata[p*8 +: 8];
      end
    end
    @(negedge clk);
  endtask

  task do_reset();
    set_in('0, '0, '0, '0, 1'b0);
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task test_reset();
    set_in('0, '0, '0, '0, 1'b0);
    reset_n = 1'b0;
    preload = 1'b1;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'(i * 37 + 11);
    model_reset();
    @(negedge clk);
    eval();
    total++; if (freeze !== 3'b000) begin bad++; $display("FAIL reset_freeze got=%b want=000", freeze); end
    total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL reset_mem_en got=%b want=0", mem_en); end
    total++; if (rd_valid !== 3'b000) begin bad++; $display("FAIL reset_rd_valid got=%b want=000", rd_valid); end
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data got=%h want=00", rd_data); end
    preload = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task test_write_read();
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      case (c)
        1: set_in(3'b010, 3'b010, {6'h00, 6'h05, 6'h00}, {8'h00, 8'hA5, 8'h00}, 1'b0);
        4: set_in(3'b100, 3'b000, {6'h05, 6'h00, 6'h00}, 24'h0, 1'b0);
        default: set_in('0, '0, '0, '0, 1'b0);
      endcase
      eval();
      total++;
      if (dut_bus !== exp_bus) begin bad++; $display("FAIL wr_rd_model c=%0d got=%h want=%h", c, dut_bus, exp_bus); end
      if (c == 2) begin
        total++;
        if ({mem_en, mem_we, mem_addr, mem_wdata, freeze} !== {1'b1, 1'b1, 6'h05, 8'hA5, 3'b010}) begin
          bad++; $display("FAIL wr_issue got=%b%b %h %h %b want=11 05 a5 010", mem_en, mem_we, mem_addr, mem_wdata, freeze);
        end
      end
      if (c == 3) begin
        total++; if (freeze !== 3'b000) begin bad++; $display("FAIL wr_freeze_fall got=%b want=000", freeze); end
      end
      if (c == 5) begin
        total++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 6'h05}) begin
          bad++; $display("FAIL rd_issue got=%b%b %h want=10 05", mem_en, mem_we, mem_addr);
        end
      end
      if (c == 6 || c == 8) begin
        total++; if (rd_valid !== 3'b000) begin bad++; $display("FAIL rd_quiet c=%0d got=%b want=000", c, rd_valid); end
      end
      if (c == 7) begin
        total++;
        if ({rd_valid, rd_data} !== {3'b100, 8'hA5}) begin
          bad++; $display("FAIL rd_return got=%b %h want=100 a5", rd_valid, rd_data);
        end
      end
      advance();
    end
  endtask

  task test_contention();
    int exp_a [16];
    for (int i = 0; i < 16; i++) exp_a[i] = -1;
    exp_a[2] = 1; exp_a[3] = 2; exp_a[4] = 3;
    exp_a[6] = 4; exp_a[7] = 5; exp_a[8] = 6;
    exp_a[10] = 7; exp_a[11] = 8;
    do_reset();
    for (int c = 1; c <= 14; c++) begin
      case (c)
        1: set_in(3'b111, 3'b000, {6'd3, 6'd2, 6'd1}, 24'h0, 1'b0);
        5: set_in(3'b111, 3'b000, {6'd6, 6'd5, 6'd4}, 24'h0, 1'b0);
        9: set_in(3'b110, 3'b000, {6'd8, 6'd7, 6'd0}, 24'h0, 1'b0);
        default: set_in('0, '0, '0, '0, 1'b0);
      endcase
      eval();
      total++;
      if (dut_bus !== exp_bus) begin bad++; $display("FAIL contention_model c=%0d got=%h want=%h", c, dut_bus, exp_bus); end
      if (exp_a[c] >= 0) begin
        total++;
        if (mem_en !== 1'b1 || mem_addr !== 6'(exp_a[c])) begin
          bad++; $display("FAIL contention_order c=%0d got en=%b addr=%0d want en=1 addr=%0d", c, mem_en, mem_addr, exp_a[c]);
        end
      end
      advance();
    end
  endtask

  task test_stall();
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      case (c)
        1: set_in(3'b101, 3'b000, {6'h0C, 6'h00, 6'h0A}, 24'h0, 1'b1);
        2, 3, 4: set_in('0, '0, '0, '0, 1'b1);
        7: set_in(3'b010, 3'b000, {6'h00, 6'h0B, 6'h00}, 24'h0, 1'b0);
        9, 10: set_in('0, '0, '0, '0, 1'b1);
        default: set_in('0, '0, '0, '0, 1'b0);
      endcase
      eval();
      total++;
      if (dut_bus !== exp_bus) begin bad++; $display("FAIL stall_model c=%0d got=%h want=%h", c, dut_bus, exp_bus); end
      if (c >= 2 && c <= 4) begin
        total++;
        if ({mem_en, freeze} !== {1'b0, 3'b101}) begin
          bad++; $display("FAIL stall_hold c=%0d got en=%b frz=%b want en=0 frz=101", c, mem_en, freeze);
        end
      end
      if (c == 5 || c == 6) begin
        total++;
        if (mem_en !== 1'b1 || mem_addr !== ((c == 5) ? 6'h0A : 6'h0C)) begin
          bad++; $display("FAIL stall_release c=%0d got en=%b addr=%h", c, mem_en, mem_addr);
        end
      end
      if (c == 10) begin
        total++;
        if ({rd_valid, rd_data} !== {3'b010, ref_mem[6'h0B]}) begin
          bad++; $display("FAIL stall_return got=%b %h want=010 %h", rd_valid, rd_data, ref_mem[6'h0B]);
        end
      end
      advance();
    end
  endtask

  task test_reset_midflight();
    do_reset();
    set_in(3'b001, 3'b000, {6'h00, 6'h00, 6'h03}, 24'h0, 1'b0);
    eval(); advance();
    set_in('0, '0, '0, '0, 1'b0);
    eval();
    total++; if (mem_en !== 1'b1) begin bad++; $display("FAIL mid_issue got=%b want=1", mem_en); end
    advance();
    reset_n = 1'b0;
    model_reset();
    eval();
    total++;
    if ({freeze, rd_valid, mem_en} !== 7'b0) begin
      bad++; $display("FAIL mid_reset got frz=%b rv=%b en=%b want 000 000 0", freeze, rd_valid, mem_en);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      if (c == 2) set_in(3'b100, 3'b000, {6'h04, 6'h00, 6'h00}, 24'h0, 1'b0);
      else        set_in('0, '0, '0, '0, 1'b0);
      eval();
      total++;
      if (dut_bus !== exp_bus) begin bad++; $display("FAIL mid_model c=%0d got=%h want=%h", c, dut_bus, exp_bus); end
      if (c == 1) begin
        total++; if (rd_valid !== 3'b000) begin bad++; $display("FAIL mid_dropped got=%b want=000", rd_valid); end
      end
      if (c == 5) begin
        total++;
        if ({rd_valid, rd_data} !== {3'b100, ref_mem[4]}) begin
          bad++; $display("FAIL mid_resume got=%b %h want=100 %h", rd_valid, rd_data, ref_mem[4]);
        end
      end
      advance();
    end
  endtask

  // Ports 0 and 1 re-request continuously: each port can only re-request
  // every other cycle, so grants alternate 0,1,0,1 in either build.
  task test_back_to_back();
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      set_in(3'b011, 3'b000, {6'h00, 6'h20, 6'h10}, 24'h0, 1'b0);
      eval();
      total++;
      if (dut_bus !== exp_bus) begin bad++; $display("FAIL b2b_model c=%0d got=%h want=%h", c, dut_bus, exp_bus); end
      if (c >= 2) begin
        total++;
        if (mem_en !== 1'b1 || mem_addr !== ((c % 2 == 0) ? 6'h10 : 6'h20)) begin
          bad++; $display("FAIL b2b_alternate c=%0d got en=%b addr=%h", c, mem_en, mem_addr);
        end
      end
      advance();
    end
  endtask

  task test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      set_in(3'($urandom), 3'($urandom),
             {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))},
             24'($urandom), ($urandom_range(0, 4) == 0));
      eval();
      total++;
      if (dut_bus !== exp_bus) begin bad++; $display("FAIL random_model c=%0d got=%h want=%h", c, dut_bus, exp_bus); end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_contention();
    test_stall();
    test_reset_midflight();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
